// File: rtl/nibble_tx_pkg.sv
// Shared types and constants for the nibble + parity serial transmitter.
package nibble_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } tx_state_t;

    localparam int DATA_BITS = 4;

    // Serial bits per frame: start + data + parity + stop bits.
    function automatic int FRAME_BITS(input int stop_bits);
        return 2 + DATA_BITS + stop_bits;
    endfunction

endpackage

// File: rtl/nibble_parity_tx_if.sv
// Valid/ready capture port between the parity generator and the transmitter.
interface nibble_parity_tx_if;
    import nibble_tx_pkg::*;

    logic [DATA_BITS-1:0] data_in;
    logic                 par_in;
    logic                 in_valid;
    logic                 in_ready;

    modport master (output data_in, output par_in, output in_valid, input in_ready);
    modport slave  (input data_in, input par_in, input in_valid, output in_ready);

endinterface

// File: rtl/bit_timer.sv
// Cycle counter for one serial bit/stop period; tick marks the final cycle of the period.
module bit_timer #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic [CW-1:0] last,
    output logic          tick
);

    logic [CW-1:0] count_reg;

    assign tick = (count_reg == last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear || tick) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/nibble_parity_tx.sv
// UART-style transmitter: start, 4 data bits LSB first, supplied parity bit, 1 or 2 stop bits.
module nibble_parity_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    nibble_parity_tx_if.slave   up,
    output logic                tx,
    output logic                busy,
    output logic                done
);
    import nibble_tx_pkg::*;

    localparam int STOP_CYCLES = STOP_BITS * CLKS_PER_BIT;
    localparam int CW          = (STOP_CYCLES > 1) ? $clog2(STOP_CYCLES) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_CYCLES - 1);

    if (CLKS_PER_BIT < 1) begin : g_bad_clks_per_bit
        $error("nibble_parity_tx: CLKS_PER_BIT must be at least 1");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("nibble_parity_tx: STOP_BITS must be 1 or 2");
    end

    tx_state_t            state_reg, state_next;
    logic [DATA_BITS:0]   shift_reg, shift_next;   // {parity, nibble}; bit 0 is on the line next
    logic [1:0]           bit_idx_reg, bit_idx_next;
    logic                 tx_reg, tx_next;
    logic                 timer_clear;
    logic [CW-1:0]        timer_last;
    logic                 tick;

    bit_timer #(.CW(CW)) u_bit_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (timer_clear),
        .last  (timer_last),
        .tick  (tick)
    );

    assign up.in_ready = (state_reg == S_IDLE);
    assign busy        = (state_reg != S_IDLE);
    assign done        = (state_reg == S_STOP) && tick;
    assign tx          = tx_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            shift_reg   <= '0;
            bit_idx_reg <= '0;
            tx_reg      <= 1'b1;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_idx_reg <= bit_idx_next;
            tx_reg      <= tx_next;
        end
    end

    // tx_next is the line level for the state being entered, so tx lines up with state.
    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_idx_next = bit_idx_reg;
        tx_next      = 1'b1;
        timer_clear  = 1'b0;
        timer_last   = BIT_LAST;

        unique case (state_reg)
            S_IDLE: begin
                timer_clear = 1'b1;
                if (up.in_valid) begin
                    state_next = S_START;
                    shift_next = {up.par_in, up.data_in};
                    tx_next    = 1'b0;
                end
            end
            S_START: begin
                tx_next = 1'b0;
                if (tick) begin
                    state_next   = S_DATA;
                    bit_idx_next = '0;
                    tx_next      = shift_reg[0];
                end
            end
            S_DATA: begin
                tx_next = shift_reg[0];
                if (tick) begin
                    shift_next   = {1'b0, shift_reg[DATA_BITS:1]};
                    tx_next      = shift_reg[1];
                    bit_idx_next = bit_idx_reg + 1'b1;
                    if (bit_idx_reg == 2'(DATA_BITS - 1)) begin
                        state_next = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                tx_next = shift_reg[0];
                if (tick) begin
                    state_next = S_STOP;
                    tx_next    = 1'b1;
                end
            end
            S_STOP: begin
                timer_last = STOP_LAST;
                if (tick) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_nibble_parity_tx.sv
// Scoreboard bench: stimulus queues expected frames, per-DUT monitors check line, done and flags.
module tb_nibble_parity_tx;

    typedef struct {
        logic [0:7] seq;        // seq[0] is the first bit on the line (start bit)
        int         nbits;
        int         mode;       // 0: absolute start cycle, 1: back-to-back, 2: aborted by reset
        int         exp_start;
    } exp_t;

    logic clk;
    logic rst_n;
    logic tx_a, busy_a, done_a;
    logic tx_b, busy_b, done_b;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t qa[$];
    exp_t qb[$];

    logic tx_s [2];
    logic busy_s [2];
    logic done_s [2];
    logic rdy_s [2];

    nibble_parity_tx_if if_a ();
    nibble_parity_tx_if if_b ();

    nibble_parity_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .up    (if_a),
        .tx    (tx_a),
        .busy  (busy_a),
        .done  (done_a)
    );

    nibble_parity_tx #(.CLKS_PER_BIT(1), .STOP_BITS(2)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .up    (if_b),
        .tx    (tx_b),
        .busy  (busy_b),
        .done  (done_b)
    );

    assign tx_s[0]   = tx_a;
    assign tx_s[1]   = tx_b;
    assign busy_s[0] = busy_a;
    assign busy_s[1] = busy_b;
    assign done_s[0] = done_a;
    assign done_s[1] = done_b;
    assign rdy_s[0]  = if_a.in_ready;
    assign rdy_s[1]  = if_b.in_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic monitor(input int id);
        int   cpb;
        int   k;
        int   len;
        int   prev_last;
        int   exp_st;
        int   done_err;
        int   flag_err;
        bit   in_frame;
        bit   got;
        exp_t cur;
        cpb       = (id == 0) ? 4 : 1;
        in_frame  = 0;
        prev_last = -100;
        k         = 0;
        len       = 0;
        done_err  = 0;
        flag_err  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                if (in_frame) begin
                    chk(cur.mode == 2, $sformatf("dut%0d_abort_expected", id), cur.mode, 2);
                end
                in_frame  = 0;
                prev_last = -100;
                chk(tx_s[id] === 1'b1 && done_s[id] === 1'b0 && busy_s[id] === 1'b0 && rdy_s[id] === 1'b1,
                    $sformatf("dut%0d_reset_state", id),
                    int'({tx_s[id], busy_s[id], done_s[id], rdy_s[id]}), 9);
            end else if (!in_frame && tx_s[id] === 1'b1) begin
                chk(done_s[id] === 1'b0 && busy_s[id] === 1'b0 && rdy_s[id] === 1'b1,
                    $sformatf("dut%0d_idle_state", id),
                    int'({busy_s[id], done_s[id], rdy_s[id]}), 1);
            end else begin
                if (!in_frame) begin
                    got = 0;
                    if (id == 0 && qa.size() > 0) begin
                        cur = qa.pop_front();
                        got = 1;
                    end else if (id == 1 && qb.size() > 0) begin
                        cur = qb.pop_front();
                        got = 1;
                    end
                    chk(got, $sformatf("dut%0d_frame_expected", id), 0, 1);
                    if (got) begin
                        exp_st = (cur.mode == 1) ? prev_last + 2 : cur.exp_start;
                        chk(cyc == exp_st, $sformatf("dut%0d_start_cycle", id), cyc, exp_st);
                        in_frame = 1;
                        k        = 0;
                        len      = cur.nbits * cpb;
                        done_err = 0;
                        flag_err = 0;
                    end
                end
                if (in_frame) begin
                    if (busy_s[id] !== 1'b1 || rdy_s[id] !== 1'b0) flag_err++;
                    if (done_s[id] !== (k == len - 1)) done_err++;
                    if (k % cpb == cpb / 2) begin
                        chk(tx_s[id] === cur.seq[k / cpb], $sformatf("dut%0d_bit%0d", id, k / cpb),
                            int'(tx_s[id]), int'(cur.seq[k / cpb]));
                    end
                    if (k == len - 1) begin
                        chk(done_err == 0, $sformatf("dut%0d_done_timing", id), done_err, 0);
                        chk(flag_err == 0, $sformatf("dut%0d_busy_ready_in_frame", id), flag_err, 0);
                        prev_last = cyc;
                        in_frame  = 0;
                    end
                    k++;
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    // Must be called just after a negedge while the target DUT is known to be idle.
    task automatic send(input int id, input logic [3:0] d, input logic p,
                        input logic [0:7] seq, input int nbits, input int mode);
        exp_t e;
        e.seq       = seq;
        e.nbits     = nbits;
        e.mode      = mode;
        e.exp_start = cyc + 1;
        if (id == 0) begin
            if_a.data_in  = d;
            if_a.par_in   = p;
            if_a.in_valid = 1'b1;
            qa.push_back(e);
        end else begin
            if_b.data_in  = d;
            if_b.par_in   = p;
            if_b.in_valid = 1'b1;
            qb.push_back(e);
        end
        @(negedge clk);
        if (id == 0) if_a.in_valid = 1'b0;
        else         if_b.in_valid = 1'b0;
    endtask

    initial begin
        exp_t e;
        if_a.data_in  = 4'b0000;
        if_a.par_in   = 1'b0;
        if_a.in_valid = 1'b0;
        if_b.data_in  = 4'b0000;
        if_b.par_in   = 1'b0;
        if_b.in_valid = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // 1011 / p=1 -> start,d,c,b,a,p,stop = 0,1,1,0,1,1,1
        send(0, 4'b1011, 1'b1, 8'b0110111_0, 7, 0);
        repeat (32) @(negedge clk);

        // 0000/p0 then 1111/p0 with in_valid held through frame one
        send(0, 4'b0000, 1'b0, 8'b0000001_0, 7, 0);
        if_a.data_in  = 4'b1111;
        if_a.par_in   = 1'b0;
        if_a.in_valid = 1'b1;
        e.seq = 8'b0111101_0;
        e.nbits = 7;
        e.mode = 1;
        e.exp_start = 0;
        qa.push_back(e);
        repeat (29) @(negedge clk);
        if_a.in_valid = 1'b0;
        repeat (32) @(negedge clk);

        // Two stop bits, one cycle per bit: 0110/p0 -> 0,0,1,1,0,0,1,1
        send(1, 4'b0110, 1'b0, 8'b00110011, 8, 0);
        repeat (12) @(negedge clk);

        // 0011/p0, reset during data bit b (frame bit 3, tx low)
        send(0, 4'b0011, 1'b0, 8'b0110001_0, 7, 2);
        repeat (13) @(negedge clk);
        #2;
        chk(tx_a === 1'b0, "pre_reset_tx", int'(tx_a), 0);
        rst_n = 1'b0;
        #1;
        chk(tx_a === 1'b1 && done_a === 1'b0 && if_a.in_ready === 1'b1, "async_reset_outputs",
            int'({tx_a, done_a, if_a.in_ready}), 5);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 1001/p0 -> 0,1,0,0,1,0,1
        send(0, 4'b1001, 1'b0, 8'b0100101_0, 7, 0);
        repeat (32) @(negedge clk);

        // 0101/p0 -> 0,1,0,1,0,0,1 while inputs churn after capture
        send(0, 4'b0101, 1'b0, 8'b0101001_0, 7, 0);
        for (int i = 0; i < 30; i++) begin
            if_a.data_in = 4'($urandom);
            if_a.par_in  = 1'($urandom);
            @(negedge clk);
        end
        repeat (5) @(negedge clk);

        chk(qa.size() == 0 && qb.size() == 0, "queues_drained", qa.size() + qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        checks++;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nibble_parity_tx.md
Name: nibble_parity_tx

Overview:
- Serial frame transmitter that sits directly downstream of the team's 4-bit parity generator.
- Captures a 4-bit data nibble plus the parity bit produced by the generator, using a valid/ready handshake.
- Shifts the capture out on one line as a UART-style frame: start bit, 4 data bits, parity bit, stop bit(s).
- Transmits the parity bit exactly as supplied; it is never recomputed here.

Parameters:
- CLKS_PER_BIT, default 4: clock cycles per serial bit. Legal range is 1 or more; elaboration fails on 0.
- STOP_BITS, default 1: number of stop bits, 1 or 2. Elaboration fails on any other value.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: reset, asynchronous and active-low.
- data_in, input, 4: nibble to send. data_in[3]=a, [2]=b, [1]=c, [0]=d, matching the generator's inputs.
- par_in, input, 1: parity bit from the generator (p).
- in_valid, input, 1: upstream has data_in/par_in valid.
- in_ready, output, 1: block can accept a nibble this cycle.
- tx, output, 1: serial line, idle high.
- busy, output, 1: a frame is in progress.
- done, output, 1: one-cycle pulse at the end of each frame.

Behaviour:
- Reset (asynchronous, while rst_n=0):
  - tx=1, in_ready=1, busy=0, done=0.
  - State=IDLE; bit counter, cycle counter and shift register all 0.
- Handshake:
  - in_ready = (state==IDLE), driven combinationally from state.
  - A transfer occurs on a rising edge where in_valid && in_ready.
  - data_in and par_in are registered on that edge. Upstream may change them freely afterwards.
  - in_valid while not ready is ignored; nothing is queued.
- States:
  - IDLE: tx=1. On transfer, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 4 bits, LSB first (d, c, b, a), each held CLKS_PER_BIT cycles. A 2-bit index counts 0..3. After bit 3, go to PARITY.
  - PARITY: tx=captured par_in for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE.
- Timing:
  - tx is registered. The start bit appears on tx in the cycle after the transfer edge.
  - Frame length on tx is (6+STOP_BITS)*CLKS_PER_BIT cycles: 28 with the defaults.
  - busy=1 in every state except IDLE.
  - done=1 for exactly one cycle: the last cycle of the last stop bit. State is IDLE and in_ready=1 in the following cycle.
- Back-to-back frames: a transfer in that first IDLE cycle starts the next frame one cycle later. The minimum inter-frame gap is therefore one extra high cycle on tx, which is legal line idle.
- Cycle counter:
  - Width is max(1, $clog2(STOP_BITS*CLKS_PER_BIT)).
  - Counts 0..N-1 within each bit/stop period, then wraps to 0 on the state or bit advance.
  - With CLKS_PER_BIT=1, every bit lasts exactly one cycle. There are no zero-length bits.
- Reset mid-frame: tx goes to 1 immediately (asynchronously) and the frame is abandoned. There is no done pulse, and in_ready=1 from reset release.
- No other event (in_valid toggling, X on data while not ready) alters an in-progress frame.

Decomposition:
- Shared package nibble_tx_pkg holds:
  - the state enum (S_IDLE, S_START, S_DATA, S_PARITY, S_STOP);
  - DATA_BITS=4;
  - the FRAME_BITS(stop) constant function returning 6+stop.
- One natural sub-module, bit_timer:
  - parameterised cycle counter with clear and load-length inputs;
  - raises a tick on the final cycle of each period.
  - The FSM, shift register and handshake stay in the top.

Test Plan:
- Reset, then idle 10 cycles with in_valid=0: tx=1, in_ready=1, busy=0, done never asserted.
- CLKS_PER_BIT=4, STOP_BITS=1; send data_in=4'b1011, par_in=1 (a^b^c^d=1):
  - tx sampled at mid-bit reads 0,1,1,0,1,1,1;
  - done pulses exactly 28 cycles after the start bit begins.
- Send 4'b0000/par_in=0, then hold in_valid=1 with 4'b1111/par_in=0:
  - second start bit begins exactly 1 cycle after the first done;
  - in_valid held during frame one is not accepted early.
- STOP_BITS=2, CLKS_PER_BIT=1, send 4'b0110/par_in=0: tx sequence 0,0,1,1,0,0,1,1; frame length 8 cycles.
- Assert rst_n=0 during DATA bit 2 of a frame:
  - tx=1 in the same cycle, no done pulse;
  - after release, a new 4'b1001 frame transmits correctly.
- Change data_in/par_in every cycle after the transfer edge: the transmitted bits match the values captured at the transfer edge.
